dma_read_master: RTL and testbench
==================================

# dma_read_master

Descriptor-execution read stage of the DMA engine, directly downstream of the descriptor fetch stage. It pops 256-bit descriptors from the descriptor FIFO and hands the destination address and length to the write master through a command handshake. It then moves the source data with Avalon-MM burst reads into the data FIFO, one burst at a time, and signals per-descriptor completion.

## Interface
- MAX_BURST, 8, maximum words per read burst (1..15)
- DFIFO_AW, 8, width of the data-FIFO free-space count
- clk  input  1  clock
- reset  input  1  reset, synchronous, active-high
- csr_control_i  input  32  bit0 = run
- desc_fifo_empty_i  input  1  descriptor FIFO empty (show-ahead FIFO)
- desc_fifo_rddata_i  input  256  head descriptor; valid whenever !empty
- desc_fifo_rd_o  output  1  pop head descriptor
- rd_read_o  output  1  Avalon burst read request
- rd_addr_o  output  32  burst start byte address
- rd_bcount_o  output  4  burst length in words
- rd_waitrequest_i  input  1  slave stall
- rd_rddata_i  input  32  read data
- rd_readdatavalid_i  input  1  read data valid
- data_fifo_wr_o  output  1  data FIFO write strobe
- data_fifo_wrdata_o  output  32  data FIFO write data
- data_fifo_free_i  input  DFIFO_AW  free word slots in the data FIFO
- wr_cmd_valid_o  output  1  write-master command valid
- wr_cmd_ready_i  input  1  write-master command accept
- wr_cmd_addr_o  output  32  destination byte address
- wr_cmd_len_o  output  32  transfer length in bytes
- desc_done_o  output  1  one-cycle pulse when all data of a descriptor has been written to the data FIFO
- busy_o  output  1  high in every state except IDLE

## Operation
- Descriptor layout: [31:0] source address, [63:32] destination address, [95:64] length in bytes, [127:96] next pointer (ignored), [255:224] control, bit 255 = owned_by_hw (ignored). Address and length bits [1:0] are ignored; word count = len[31:2].
- States:
  - IDLE: if run and !desc_fifo_empty_i -> LOAD.
  - LOAD: latch src, dst, and word count; pulse desc_fifo_rd_o for one cycle -> CMD.
  - CMD: wr_cmd_valid_o held high with a stable address and length until wr_cmd_valid_o && wr_cmd_ready_i -> CHECK.
  - CHECK:
    - remaining == 0 -> DONE.
    - Else compute burst = min(remaining, MAX_BURST).
    - If data_fifo_free_i >= burst -> SEND_READ, else stay.
  - SEND_READ: rd_read_o held high with a stable address and bcount until !rd_waitrequest_i -> WAIT_DATA.
  - WAIT_DATA:
    - Every rd_readdatavalid_i beat writes to the data FIFO.
    - After the final beat: remaining -= burst, src += 4*burst -> CHECK.
  - DONE: pulse desc_done_o; run -> IDLE-equivalent fetch of the next descriptor (next state IDLE); !run -> IDLE.
- Zero-length descriptor: the write command is still issued with wr_cmd_len_o = 0. There are no reads, and desc_done_o pulses.
- Deasserting run mid-descriptor: the current descriptor completes. Run is sampled only in IDLE and DONE.
- Address arithmetic is 32-bit and wraps modulo 2^32. The beat counter is 4 bits.
- Only one burst is outstanding at a time. No read is issued until every beat of the previous burst has been received.

## Timing
- Reset values: all 1-bit outputs 0; rd_addr_o, rd_bcount_o, wr_cmd_addr_o, wr_cmd_len_o, and data_fifo_wrdata_o all 0; state = IDLE.
- Reset mid-operation: IDLE on the next edge. In-flight beats are dropped.
- data_fifo_wr_o and data_fifo_wrdata_o are registered: one cycle after each rd_readdatavalid_i.
- Latency:
  - IDLE with a descriptor present -> desc_fifo_rd_o at cycle 1.
  - wr_cmd_valid_o at cycle 2.
  - With ready already high, rd_read_o is at cycle 4.
- The space check in CHECK uses data_fifo_free_i as sampled that cycle.
- desc_done_o asserts the cycle after the registered final data write.

## Test plan
- Descriptor src=0x1000, dst=0x2000, len=32, zero waitrequest, ready high:
  - exactly one command: 0x2000/32.
  - one burst: addr 0x1000, bcount 8.
  - 8 FIFO writes, then one desc_done_o.
- len=44 with MAX_BURST=8: bursts of 8 words @0x1000 and 3 words @0x1020; 11 data writes total.
- Stalls: waitrequest high for 5 cycles, then wr_cmd_ready_i low for 3 cycles. Address, bcount, and command fields stay stable; no duplicate requests are issued.
- data_fifo_free_i=4 with a burst of 8: the block holds in CHECK with no rd_read_o. Raising free to 8 issues the burst the next cycle.
- Back-to-back descriptors, one with len=0 followed by len=16:
  - len=0: command issued with length 0, no reads, done pulse.
  - len=16: one 4-word burst, done pulse; total of 2 desc_done_o pulses.
- reset asserted in WAIT_DATA after 3 of 8 beats: all outputs return to 0 the next cycle. Later beats produce no data_fifo_wr_o.

Source files
------------

// File: rtl/dma_read_master.sv
// dma_read_master: executes descriptors by issuing a write command, then burst-reading source data into the data FIFO.
module dma_read_master #(
   parameter int MAX_BURST = 8,
   parameter int DFIFO_AW  = 8
) (
   input  logic                clk,
   input  logic                reset,
   input  logic [31:0]         csr_control_i,
   input  logic                desc_fifo_empty_i,
   input  logic [255:0]        desc_fifo_rddata_i,
   output logic                desc_fifo_rd_o,
   output logic                rd_read_o,
   output logic [31:0]         rd_addr_o,
   output logic [3:0]          rd_bcount_o,
   input  logic                rd_waitrequest_i,
   input  logic [31:0]         rd_rddata_i,
   input  logic                rd_readdatavalid_i,
   output logic                data_fifo_wr_o,
   output logic [31:0]         data_fifo_wrdata_o,
   input  logic [DFIFO_AW-1:0] data_fifo_free_i,
   output logic                wr_cmd_valid_o,
   input  logic                wr_cmd_ready_i,
   output logic [31:0]         wr_cmd_addr_o,
   output logic [31:0]         wr_cmd_len_o,
   output logic                desc_done_o,
   output logic                busy_o
);
   typedef enum logic [2:0] {IDLE, LOAD, CMD, CHECK, SEND_READ, WAIT_DATA, DONE} state_t;
   state_t      state, state_nx;
   logic [31:0] src, dst, len;
   logic [29:0] remaining;
   logic [3:0]  bcount, beat, burst;
   logic        fits, last_beat, beat_in, unused_bits;
   assign burst     = (remaining < 30'(MAX_BURST)) ? remaining[3:0] : 4'(MAX_BURST);
   assign fits      = 32'(data_fifo_free_i) >= 32'(burst);
   assign beat_in   = (state == WAIT_DATA) && rd_readdatavalid_i;
   assign last_beat = beat_in && (beat == bcount - 4'd1);
   assign desc_fifo_rd_o = state == LOAD;
   assign wr_cmd_valid_o = state == CMD;
   assign rd_read_o      = state == SEND_READ;
   assign desc_done_o    = state == DONE;
   assign busy_o         = state != IDLE;
   assign rd_addr_o      = src;
   assign rd_bcount_o    = bcount;
   assign wr_cmd_addr_o  = dst;
   assign wr_cmd_len_o   = len;
   // Byte-offset bits, link pointer, control word and spare CSR bits carry no meaning here.
   assign unused_bits = ^{csr_control_i[31:1], desc_fifo_rddata_i[255:96], desc_fifo_rddata_i[65:64],
                          desc_fifo_rddata_i[33:32], desc_fifo_rddata_i[1:0]};
   always_comb begin
      state_nx = state;
      case (state)
         IDLE:      state_nx = (csr_control_i[0] && !desc_fifo_empty_i) ? LOAD : IDLE;
         LOAD:      state_nx = CMD;
         CMD:       state_nx = wr_cmd_ready_i ? CHECK : CMD;
         CHECK:     state_nx = (remaining == '0) ? DONE : (fits ? SEND_READ : CHECK);
         SEND_READ: state_nx = rd_waitrequest_i ? SEND_READ : WAIT_DATA;
         WAIT_DATA: state_nx = last_beat ? CHECK : WAIT_DATA;
         default:   state_nx = IDLE;
      endcase
   end
   always_ff @(posedge clk) begin
      if (reset) begin
         state              <= IDLE;
         src                <= '0;
         dst                <= '0;
         len                <= '0;
         remaining          <= '0;
         bcount             <= '0;
         beat               <= '0;
         data_fifo_wr_o     <= 1'b0;
         data_fifo_wrdata_o <= '0;
      end else begin
         state          <= state_nx;
         data_fifo_wr_o <= beat_in;
         if (beat_in) begin
            data_fifo_wrdata_o <= rd_rddata_i;
            beat               <= beat + 4'd1;
         end
         if (state == LOAD) begin
            src       <= {desc_fifo_rddata_i[31:2], 2'b00};
            dst       <= {desc_fifo_rddata_i[63:34], 2'b00};
            len       <= {desc_fifo_rddata_i[95:66], 2'b00};
            remaining <= desc_fifo_rddata_i[95:66];
         end
         if (state == CHECK && remaining != '0 && fits) begin
            bcount <= burst;
            beat   <= '0;
         end
         if (last_beat) begin
            remaining <= remaining - 30'(bcount);
            src       <= src + {26'd0, bcount, 2'b00};
         end
      end
   end
endmodule

// File: tb/tb_dma_read_master.sv
// tb_dma_read_master: table vectors, corner sequences and random descriptors against a transfer-level model.
module tb_dma_read_master;
   localparam int MAXB = 8;
   logic         clk, reset;
   logic [31:0]  csr_control_i;
   logic         desc_fifo_empty_i;
   logic [255:0] desc_fifo_rddata_i;
   logic         desc_fifo_rd_o, rd_read_o, rd_waitrequest_i, rd_readdatavalid_i;
   logic [31:0]  rd_addr_o, rd_rddata_i, data_fifo_wrdata_o, wr_cmd_addr_o, wr_cmd_len_o;
   logic [3:0]   rd_bcount_o;
   logic         data_fifo_wr_o, wr_cmd_valid_o, wr_cmd_ready_i, desc_done_o, busy_o;
   logic [7:0]   data_fifo_free_i;

   dma_read_master #(.MAX_BURST(MAXB), .DFIFO_AW(8)) dut (
      .clk(clk), .reset(reset), .csr_control_i(csr_control_i),
      .desc_fifo_empty_i(desc_fifo_empty_i), .desc_fifo_rddata_i(desc_fifo_rddata_i),
      .desc_fifo_rd_o(desc_fifo_rd_o), .rd_read_o(rd_read_o), .rd_addr_o(rd_addr_o),
      .rd_bcount_o(rd_bcount_o), .rd_waitrequest_i(rd_waitrequest_i), .rd_rddata_i(rd_rddata_i),
      .rd_readdatavalid_i(rd_readdatavalid_i), .data_fifo_wr_o(data_fifo_wr_o),
      .data_fifo_wrdata_o(data_fifo_wrdata_o), .data_fifo_free_i(data_fifo_free_i),
      .wr_cmd_valid_o(wr_cmd_valid_o), .wr_cmd_ready_i(wr_cmd_ready_i), .wr_cmd_addr_o(wr_cmd_addr_o),
      .wr_cmd_len_o(wr_cmd_len_o), .desc_done_o(desc_done_o), .busy_o(busy_o)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   typedef struct {logic [31:0] src, dst, len; int nb, nw;} vec_t;
   vec_t         tbl [6];
   logic [255:0] dq[$];
   logic [63:0]  exp_cmd[$], obs_cmd[$], exp_burst[$], obs_burst[$];
   logic [31:0]  exp_data[$], obs_data[$], beats[$];
   int           total, bad, n_done, rd_cycles, cmd_cycles, pop_cycles, unstable, beats_sent, rd_stall, rdy_stall;
   bit           rnd, hold, pop_pend, prev_rd, prev_cmd;
   logic [35:0]  prev_rdf;
   logic [63:0]  prev_cmdf;
   logic [7:0]   free_val;
   logic [2:0]   lat [1:4];

   function automatic logic [31:0] pat(logic [31:0] a);
      return a ^ 32'h5A5A_C3C3;
   endfunction

   task automatic check(string name, logic [63:0] got, logic [63:0] want);
      total++;
      if (got !== want) begin
         bad++;
         $display("FAIL %s: got %h expected %h", name, got, want);
      end
   endtask

   // Transfer-level model: one command per descriptor, then min(remaining, MAXB)-word bursts.
   task automatic push_desc(logic [31:0] s, logic [31:0] d, logic [31:0] l);
      logic [255:0] v;
      logic [31:0]  a;
      int           w, b;
      v = '0;
      v[31:0] = s; v[63:32] = d; v[95:64] = l; v[127:96] = $urandom; v[255] = 1'b1;
      dq.push_back(v);
      exp_cmd.push_back({d & ~32'h3, l & ~32'h3});
      w = int'(l >> 2);
      a = s & ~32'h3;
      while (w > 0) begin
         b = (w < MAXB) ? w : MAXB;
         exp_burst.push_back({a, 32'(b)});
         for (int i = 0; i < b; i++) exp_data.push_back(pat(a + 32'(4 * i)));
         a += 32'(4 * b);
         w -= b;
      end
   endtask

   // One negedge: observe DUT outputs, then drive the FIFO, slave and write-master inputs for the next edge.
   task automatic step();
      @(negedge clk);
      if (data_fifo_wr_o) obs_data.push_back(data_fifo_wrdata_o);
      if (desc_done_o) n_done++;
      if (rd_read_o) rd_cycles++;
      if (wr_cmd_valid_o) cmd_cycles++;
      if (desc_fifo_rd_o) pop_cycles++;
      if (rd_read_o && prev_rd && {rd_addr_o, rd_bcount_o} != prev_rdf) unstable++;
      if (wr_cmd_valid_o && prev_cmd && {wr_cmd_addr_o, wr_cmd_len_o} != prev_cmdf) unstable++;
      prev_rd = rd_read_o; prev_rdf = {rd_addr_o, rd_bcount_o};
      prev_cmd = wr_cmd_valid_o; prev_cmdf = {wr_cmd_addr_o, wr_cmd_len_o};
      if (pop_pend && dq.size() > 0) dq.delete(0);
      pop_pend = desc_fifo_rd_o;
      if (!hold && beats.size() > 0 && (!rnd || $urandom_range(0, 2) != 0)) begin
         rd_readdatavalid_i = 1'b1;
         rd_rddata_i = beats.pop_front();
         beats_sent++;
      end else begin
         rd_readdatavalid_i = 1'b0;
         rd_rddata_i = $urandom;
      end
      if (rd_read_o && rd_stall > 0) begin
         rd_waitrequest_i = 1'b1;
         rd_stall--;
      end else rd_waitrequest_i = rnd && ($urandom_range(0, 3) == 0);
      if (rd_read_o && !rd_waitrequest_i) begin
         obs_burst.push_back({rd_addr_o, 28'd0, rd_bcount_o});
         for (int i = 0; i < int'(rd_bcount_o); i++) beats.push_back(pat(rd_addr_o + 32'(4 * i)));
      end
      if (wr_cmd_valid_o && rdy_stall > 0) begin
         wr_cmd_ready_i = 1'b0;
         rdy_stall--;
      end else wr_cmd_ready_i = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
      if (wr_cmd_valid_o && wr_cmd_ready_i) obs_cmd.push_back({wr_cmd_addr_o, wr_cmd_len_o});
      data_fifo_free_i = rnd ? 8'($urandom_range(0, 15)) : free_val;
      desc_fifo_empty_i = dq.size() == 0;
      desc_fifo_rddata_i = (dq.size() > 0) ? dq[0] : '0;
   endtask

   task automatic clear_obs();
      exp_cmd.delete(); obs_cmd.delete(); exp_burst.delete(); obs_burst.delete();
      exp_data.delete(); obs_data.delete(); beats.delete();
      n_done = 0; rd_cycles = 0; cmd_cycles = 0; pop_cycles = 0; unstable = 0; beats_sent = 0;
   endtask

   task automatic wait_done(int n, int budget);
      int c;
      c = 0;
      while (n_done < n && c < budget) begin
         step();
         c++;
      end
      repeat (4) step();
      check("done_count", 64'(n_done), 64'(n));
   endtask

   task automatic compare_all();
      check("cmd_count", 64'(obs_cmd.size()), 64'(exp_cmd.size()));
      for (int i = 0; i < obs_cmd.size() && i < exp_cmd.size(); i++) check("cmd", obs_cmd[i], exp_cmd[i]);
      check("burst_count", 64'(obs_burst.size()), 64'(exp_burst.size()));
      for (int i = 0; i < obs_burst.size() && i < exp_burst.size(); i++) check("burst", obs_burst[i], exp_burst[i]);
      check("data_count", 64'(obs_data.size()), 64'(exp_data.size()));
      for (int i = 0; i < obs_data.size() && i < exp_data.size(); i++) check("data", 64'(obs_data[i]), 64'(exp_data[i]));
   endtask

   function automatic logic any_out();
      return |{desc_fifo_rd_o, rd_read_o, rd_addr_o, rd_bcount_o, data_fifo_wr_o, data_fifo_wrdata_o,
               wr_cmd_valid_o, wr_cmd_addr_o, wr_cmd_len_o, desc_done_o, busy_o};
   endfunction

   initial begin
      int c;
      total = 0; bad = 0; rnd = 0; hold = 0; pop_pend = 0; prev_rd = 0; prev_cmd = 0;
      prev_rdf = '0; prev_cmdf = '0; rd_stall = 0; rdy_stall = 0; free_val = 8'd255;
      reset = 1'b1; csr_control_i = 32'h1; desc_fifo_empty_i = 1'b1; desc_fifo_rddata_i = '0;
      rd_waitrequest_i = 1'b0; rd_rddata_i = '0; rd_readdatavalid_i = 1'b0; wr_cmd_ready_i = 1'b1;
      data_fifo_free_i = 8'd255;
      clear_obs();
      tbl[0] = '{32'h0000_1000, 32'h0000_2000, 32'd32, 1, 8};
      tbl[1] = '{32'h0000_1000, 32'h0000_3000, 32'd44, 2, 11};
      tbl[2] = '{32'h0000_4002, 32'h0000_5001, 32'd19, 1, 4};
      tbl[3] = '{32'hFFFF_FFF0, 32'h0000_0100, 32'd40, 2, 10};
      tbl[4] = '{32'h0000_8000, 32'h0000_9000, 32'd120, 4, 30};
      tbl[5] = '{32'h0000_0000, 32'h0000_0040, 32'd3, 0, 0};
      repeat (3) step();
      check("reset_outputs_zero", 64'(any_out()), 64'd0);
      reset = 1'b0;

      foreach (tbl[i]) begin
         clear_obs();
         push_desc(tbl[i].src, tbl[i].dst, tbl[i].len);
         wait_done(1, 500);
         compare_all();
         check("tbl_bursts", 64'(obs_burst.size()), 64'(tbl[i].nb));
         check("tbl_words", 64'(obs_data.size()), 64'(tbl[i].nw));
      end

      clear_obs();
      push_desc(32'h1000, 32'h2000, 32'd32);
      step();
      for (int k = 1; k <= 4; k++) begin
         step();
         lat[k] = {desc_fifo_rd_o, wr_cmd_valid_o, rd_read_o};
      end
      check("lat_pop_c1", 64'(lat[1]), 64'(3'b100));
      check("lat_cmd_c2", 64'(lat[2]), 64'(3'b010));
      check("lat_check_c3", 64'(lat[3]), 64'(3'b000));
      check("lat_read_c4", 64'(lat[4]), 64'(3'b001));
      wait_done(1, 500);
      compare_all();

      clear_obs();
      rd_stall = 5; rdy_stall = 3;
      push_desc(32'h1000, 32'h2000, 32'd32);
      wait_done(1, 500);
      compare_all();
      check("stall_stable", 64'(unstable), 64'd0);
      check("stall_read_cycles", 64'(rd_cycles), 64'd6);
      check("stall_cmd_cycles", 64'(cmd_cycles), 64'd4);

      clear_obs();
      free_val = 8'd4;
      push_desc(32'h1000, 32'h2000, 32'd32);
      repeat (15) step();
      check("space_no_read", 64'(rd_cycles), 64'd0);
      check("space_busy", 64'(busy_o), 64'd1);
      free_val = 8'd8;
      step();
      step();
      check("space_read_next", 64'(rd_read_o), 64'd1);
      free_val = 8'd255;
      wait_done(1, 500);
      compare_all();

      clear_obs();
      push_desc(32'h0000_0010, 32'h0000_00A0, 32'd0);
      push_desc(32'h0000_2000, 32'h0000_3000, 32'd16);
      wait_done(2, 500);
      compare_all();
      check("b2b_bursts", 64'(obs_burst.size()), 64'd1);

      clear_obs();
      csr_control_i = 32'h0;
      push_desc(32'h0000_6000, 32'h0000_7000, 32'd8);
      repeat (6) step();
      check("norun_idle", 64'(busy_o), 64'd0);
      check("norun_no_pop", 64'(pop_cycles), 64'd0);
      csr_control_i = 32'h1;
      wait_done(1, 500);
      compare_all();

      clear_obs();
      push_desc(32'h1000, 32'h2000, 32'd32);
      c = 0;
      while (beats_sent < 3 && c < 200) begin
         step();
         c++;
      end
      hold = 1;
      step();
      check("abort_in_flight", 64'(busy_o), 64'd1);
      reset = 1'b1;
      step();
      check("abort_outputs_zero", 64'(any_out()), 64'd0);
      reset = 1'b0; hold = 0;
      obs_data.delete(); rd_cycles = 0;
      repeat (12) step();
      check("abort_no_writes", 64'(obs_data.size()), 64'd0);
      check("abort_no_reads", 64'(rd_cycles), 64'd0);
      check("abort_idle", 64'(busy_o), 64'd0);

      clear_obs();
      rnd = 1;
      for (int i = 0; i < 20; i++)
         push_desc(($urandom_range(0, 3) == 0) ? 32'hFFFF_FFC0 + 32'($urandom_range(0, 63)) : $urandom,
                   $urandom, 32'($urandom_range(0, 100)));
      wait_done(20, 30000);
      rnd = 0;
      repeat (3) step();
      compare_all();

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
